// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared state encoding and parameter defaults for period_meter
package period_meter_pkg;

  localparam int DEF_CNT_W   = 22;
  localparam int DEF_MAX_CNT = 'h3FFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sync_rise.sv
// rtl/sync_rise.sv - two-flop synchronizer plus rising-edge detector for an async input
module sync_rise (
  input  logic clk,
  input  logic rst_clk,
  input  logic sig,
  output logic rise
);

  // sh[0] metastable stage, sh[1] synchronized value, sh[2] its previous-cycle copy
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      sh <= '0;
    end else begin
      sh <= {sh[1:0], sig};
    end
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures sig_in rising-edge period in clk cycles, single-shot or continuous
module period_meter
  import period_meter_pkg::*;
#(
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEF_MAX_CNT)
) (
  input  logic             clk,
  input  logic             rst_clk,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rise;

  sync_rise u_sync_rise (
    .clk     (clk),
    .rst_clk (rst_clk),
    .sig     (sig_in),
    .rise    (rise)
  );

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ARM;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (rise) begin
            state <= ST_MEASURE;
            cnt   <= CNT_W'(1);
          end else if (cnt == MAX_CNT - CNT_W'(1)) begin
            // The increment that would reach the limit ends the wait instead
            state   <= ST_DONE;
            cnt     <= MAX_CNT;
            period  <= '0;
            timeout <= 1'b1;
            valid   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            // A rise coinciding with the limit is still a real measurement
            period  <= cnt;
            timeout <= 1'b0;
            valid   <= 1'b1;
            cnt     <= CNT_W'(1);
            if (!cont) begin
              state <= ST_DONE;
            end
          end else if (cnt == MAX_CNT) begin
            state   <= ST_DONE;
            period  <= '0;
            timeout <= 1'b1;
            valid   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter with directed sig_in patterns
module tb_period_meter;

  localparam int            CW = 22;
  localparam logic [CW-1:0] MC = 22'd1000;

  logic          clk = 1'b0;
  logic          rst_clk = 1'b0;
  logic          sig_in = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic [CW-1:0] period;
  logic          valid;
  logic          timeout;
  logic          busy;

  period_meter #(.CNT_W(CW), .MAX_CNT(MC)) dut (
    .clk     (clk),
    .rst_clk (rst_clk),
    .sig_in  (sig_in),
    .start   (start),
    .cont    (cont),
    .period  (period),
    .valid   (valid),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0] period;
    logic          tmo;
    int            at;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push(input int p, input bit t, input int at);
    exp_t e;
    e.period = CW'(p);
    e.tmo    = t;
    e.at     = at;
    q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One sig_in period of length p starting with a rise; optional start pulse alongside
  task automatic gen_period(input int p, input bit sp);
    sig_in = 1'b1;
    start  = sp;
    @(negedge clk);
    start = 1'b0;
    repeat (p / 2 - 1) @(negedge clk);
    sig_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 32'(n < 6000), 32'd1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_period"}, 32'(period), 32'd0);
    check({name, "_valid"}, 32'(valid), 32'd0);
    check({name, "_timeout"}, 32'(timeout), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_clk && valid) begin
            if (q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_valid: got period=%0d timeout=%0d want no result", period, timeout);
            end else begin
              e = q.pop_front();
              check("res_period", 32'(period), 32'(e.period));
              check("res_timeout", 32'(timeout), 32'(e.tmo));
              if (e.at >= 0) check("res_cycle", 32'(cyc), 32'(e.at));
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_clk = 1'b1;
    repeat (5) @(negedge clk);

    // single shot, period 100
    push(100, 0, -1);
    do_start();
    repeat (3) gen_period(100, 1'b0);
    wait_idle("t1");
    check("t1_hold_period", 32'(period), 32'd100);
    check("t1_hold_timeout", 32'(timeout), 32'd0);

    // continuous: 40, 60, 50 then stop
    cont = 1'b1;
    push(40, 0, -1);
    push(60, 0, -1);
    push(50, 0, -1);
    do_start();
    gen_period(40, 1'b0);
    gen_period(60, 1'b0);
    gen_period(50, 1'b0);
    cont = 1'b0;
    gen_period(20, 1'b0);
    wait_idle("t2");

    // minimum period 4, stray start pulses while busy
    cont = 1'b1;
    for (int i = 0; i < 9; i++) push(4, 0, -1);
    do_start();
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) cont = 1'b0;
      gen_period(4, (i == 3 || i == 6));
    end
    wait_idle("t3");

    // no edge at all: timeout exactly MAX_CNT cycles after entering ARM
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push(0, 1, cyc + 1000);
    wait_idle("t4");
    check("t4_busy", 32'(busy), 32'd0);

    // period equal to MAX_CNT is still a measurement
    do_start();
    gen_period(1000, 1'b0);
    push(1000, 0, -1);
    gen_period(10, 1'b0);
    wait_idle("t5");

    // one edge then silence: timeout from MEASURE
    do_start();
    repeat (2) @(negedge clk);
    sig_in = 1'b1;
    push(0, 1, cyc + 1003);
    repeat (5) @(negedge clk);
    sig_in = 1'b0;
    wait_idle("t6");

    // reset in the middle of a measurement
    do_start();
    gen_period(100, 1'b0);
    check("t7_busy_before", 32'(busy), 32'd1);
    rst_clk = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("t7_rst");
    end
    rst_clk = 1'b1;
    repeat (2) gen_period(100, 1'b0);
    check("t7_no_restart", 32'(busy), 32'd0);
    push(100, 0, -1);
    do_start();
    repeat (3) gen_period(100, 1'b0);
    wait_idle("t7");

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
